// File: rtl/seg_snake_driver.sv
// seg_snake_driver: snake animation engine for an N-digit 7-segment display.
// A SNAKE_LEN-segment snake runs around the outer perimeter of the whole display,
// advancing one path position every TICK_DIV clock cycles while running.
//
// Path (P = 2*NUM_DIGITS+4 positions): a of digits 0..N-1, b and c of digit N-1,
// d of digits N-1..0, then e and f of digit 0. Segment g is never lit.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   en        1 = run, 0 = hold
//   dir       0 = clockwise, 1 = counter-clockwise (sampled on each step)
//   seg_n     active-low segments, digit d = seg_n[7d+6:7d], bit6=a .. bit0=g
//   dpt_n     active-low decimal points
//   head_pos  current head path position
//   lap       one-cycle pulse after a step whose head update wrapped
//
// Build option: define SNAKE_HEAD_DP_EN to light the decimal point of the digit
// that owns the head segment; otherwise dpt_n is tied high.
module seg_snake_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 5_000_000,
  parameter int unsigned SNAKE_LEN  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 dir,
  output logic [7*NUM_DIGITS-1:0]              seg_n,
  output logic [NUM_DIGITS-1:0]                dpt_n,
  output logic [$clog2(2*NUM_DIGITS+4)-1:0]    head_pos,
  output logic                                 lap
);

  localparam int unsigned P       = 2 * NUM_DIGITS + 4;
  localparam int unsigned PW      = $clog2(P);
  localparam int unsigned CW      = $clog2(TICK_DIV);
  localparam int unsigned SegW    = 7 * NUM_DIGITS;
  localparam int unsigned SegIdxW = $clog2(SegW);

  typedef enum logic [1:0] {StBlank, StRun, StHold} st_e;

  st_e               st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     head_q, head_d;
  logic              dir_q, dir_d;
  logic              lap_q, lap_d;
  logic [SegW-1:0]   seg_n_q, seg_n_d;
  logic              tick, wrap;
  logic [31:0]       head_w, off_raw, off;

  // Flat seg_n bit index of the segment at a given path position.
  function automatic int unsigned seg_index(int unsigned pos);
    if (pos < NUM_DIGITS)                 return 7 * pos + 6;
    else if (pos == NUM_DIGITS)           return 7 * (NUM_DIGITS - 1) + 5;
    else if (pos == NUM_DIGITS + 1)       return 7 * (NUM_DIGITS - 1) + 4;
    else if (pos <= 2 * NUM_DIGITS + 1)   return 7 * (2 * NUM_DIGITS + 1 - pos) + 3;
    else if (pos == 2 * NUM_DIGITS + 2)   return 2;
    else                                  return 1;
  endfunction

  always_comb begin
    tick = (st_q == StRun) && (cnt_q == CW'(TICK_DIV - 1));

    st_d = st_q;
    case (st_q)
      StBlank: if (en)  st_d = StRun;
      StRun:   if (!en) st_d = StHold;
      StHold:  if (en)  st_d = StRun;
      default:          st_d = StBlank;
    endcase

    // Counter only advances while running; HOLD/BLANK keep the partial step.
    cnt_d = cnt_q;
    if (st_q == StRun) cnt_d = tick ? '0 : cnt_q + CW'(1);

    head_d = head_q;
    dir_d  = dir_q;
    wrap   = 1'b0;
    if (tick) begin
      dir_d = dir;
      if (dir) begin
        wrap   = (head_q == '0);
        head_d = wrap ? PW'(P - 1) : head_q - PW'(1);
      end else begin
        wrap   = (head_q == PW'(P - 1));
        head_d = wrap ? '0 : head_q + PW'(1);
      end
    end
    lap_d = tick && wrap;
  end

  // A position is lit when its distance behind the head (against the motion
  // direction, mod P) is below SNAKE_LEN.
  always_comb begin
    seg_n_d = '1;
    head_w  = 32'(head_q);
    off_raw = '0;
    off     = '0;
    if (st_q != StBlank) begin
      for (int unsigned p = 0; p < P; p++) begin
        off_raw = dir_q ? (p + P - head_w) : (head_w + P - p);
        off     = (off_raw >= P) ? off_raw - P : off_raw;
        if (off < SNAKE_LEN) seg_n_d[SegIdxW'(seg_index(p))] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StBlank;
      cnt_q   <= '0;
      head_q  <= '0;
      dir_q   <= 1'b0;
      lap_q   <= 1'b0;
      seg_n_q <= '1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      dir_q   <= dir_d;
      lap_q   <= lap_d;
      seg_n_q <= seg_n_d;
    end
  end

`ifdef SNAKE_HEAD_DP_EN
  logic [NUM_DIGITS-1:0] dpt_n_q, dpt_n_d;
  logic [31:0]           head_seg;

  // Digit owning the head segment: seg_index / 7.
  always_comb begin
    dpt_n_d  = '1;
    head_seg = seg_index(32'(head_q));
    if (st_q != StBlank) begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        if (head_seg / 7 == d) dpt_n_d[d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dpt_n_q <= '1;
    else     dpt_n_q <= dpt_n_d;
  end

  assign dpt_n = dpt_n_q;
`else
  assign dpt_n = '1;
`endif

  assign seg_n    = seg_n_q;
  assign head_pos = head_q;
  assign lap      = lap_q;

endmodule

// File: tb/tb_seg_snake_driver.sv
// Self-checking bench for seg_snake_driver (NUM_DIGITS=2, TICK_DIV=4, SNAKE_LEN=3).
module tb_seg_snake_driver;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int L  = 3;
  localparam int P  = 2 * N + 4;
  localparam int PW = $clog2(P);
  localparam int SW = 7 * N;
  localparam int SEG_ALL = (1 << SW) - 1;
  localparam int DPT_ALL = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          dir = 1'b0;
  logic [SW-1:0] seg_n;
  logic [N-1:0]  dpt_n;
  logic [PW-1:0] head_pos;
  logic          lap;

  seg_snake_driver #(
    .NUM_DIGITS(N),
    .TICK_DIV  (TD),
    .SNAKE_LEN (L)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dir     (dir),
    .seg_n   (seg_n),
    .dpt_n   (dpt_n),
    .head_pos(head_pos),
    .lap     (lap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Path position -> (digit, segment bit), built from the path description.
  int pdig[P];
  int pbit[P];

  // Reference model: mode 0=blank 1=run 2=hold.
  int m_mode = 0, m_cnt = 0, m_head = 0, m_dir = 0;
  int e_seg = SEG_ALL, e_dpt = DPT_ALL, e_lap = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int render(input int mode, input int head, input int mdir);
    int v = SEG_ALL;
    if (mode == 0) return v;
    for (int k = 0; k < L; k++) begin
      int p;
      p = mdir != 0 ? (head + k) % P : (head - k + P) % P;
      v &= ~(1 << (7 * pdig[p] + pbit[p]));
    end
    return v;
  endfunction

  // Apply inputs for one clock, advance the model, compare all outputs.
  task automatic step(input logic r, input logic e, input logic d);
    int tick, wrap, nseg, ndpt;
    rst = r; en = e; dir = d;
    nseg = r ? SEG_ALL : render(m_mode, m_head, m_dir);
    ndpt = DPT_ALL;
`ifdef SNAKE_HEAD_DP_EN
    if (!r && m_mode != 0) ndpt &= ~(1 << pdig[m_head]);
`endif
    if (r) begin
      m_mode = 0; m_cnt = 0; m_head = 0; m_dir = 0; e_lap = 0;
    end else begin
      tick = (m_mode == 1 && m_cnt == TD - 1) ? 1 : 0;
      wrap = 0;
      if (tick != 0) begin
        if (d) begin
          wrap = (m_head == 0) ? 1 : 0;
          m_head = (m_head + P - 1) % P;
        end else begin
          wrap = (m_head == P - 1) ? 1 : 0;
          m_head = (m_head + 1) % P;
        end
        m_dir = d ? 1 : 0;
        m_cnt = 0;
      end else if (m_mode == 1) begin
        m_cnt++;
      end
      case (m_mode)
        0: if (e)  m_mode = 1;
        1: if (!e) m_mode = 2;
        default: if (e) m_mode = 1;
      endcase
      e_lap = (tick != 0 && wrap != 0) ? 1 : 0;
    end
    e_seg = nseg;
    e_dpt = ndpt;
    @(posedge clk);
    #1;
    check("seg_n", int'(seg_n), e_seg);
    check("dpt_n", int'(dpt_n), e_dpt);
    check("head_pos", int'(head_pos), m_head);
    check("lap", int'(lap), e_lap);
  endtask

  typedef struct {
    logic r;
    logic e;
    logic d;
    int   head;
    int   lap;
    int   seg;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int laps, found;

    for (int p = 0; p < N; p++) begin pdig[p] = p; pbit[p] = 6; end
    pdig[N] = N - 1;     pbit[N] = 5;
    pdig[N + 1] = N - 1; pbit[N + 1] = 4;
    for (int p = N + 2; p <= 2 * N + 1; p++) begin pdig[p] = 2 * N + 1 - p; pbit[p] = 3; end
    pdig[2 * N + 2] = 0; pbit[2 * N + 2] = 2;
    pdig[2 * N + 3] = 0; pbit[2 * N + 3] = 1;

    // Reset, blank while en=0, then run clockwise through the first step.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 'h3FFF};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 'h3FFF};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 0, 0, 'h3FFF};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 0, 0, 'h3FFF};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 0, 0, 'h3FFF};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 0, 0, 'h3FB9};  // a0,e0,f0 lit
    tbl[6] = '{1'b0, 1'b1, 1'b0, 0, 0, 'h3FB9};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 0, 0, 'h3FB9};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1, 0, 'h3FB9};  // first tick
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1, 0, 'h1FBD};  // a1,a0,f0 lit

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d);
      check($sformatf("tbl%0d_seg", i), int'(seg_n), tbl[i].seg);
      check($sformatf("tbl%0d_head", i), int'(head_pos), tbl[i].head);
      check($sformatf("tbl%0d_lap", i), int'(lap), tbl[i].lap);
    end

    // Clockwise to the 7->0 wrap: exactly one lap pulse.
    laps = 0; found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (lap) laps++;
      if (head_pos == 0 && lap) found = 1;
    end
    check("wrap_cw_found", found, 1);
    check("wrap_cw_laps", laps, 1);

    // Reverse from head 0: next step wraps to 7 with a lap pulse.
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (head_pos != 0) found = 1;
    end
    check("rev_head", int'(head_pos), 7);
    check("rev_lap", int'(lap), 1);
    step(1'b0, 1'b1, 1'b1);
    check("rev_seg", int'(seg_n), 'h1FBD);  // f0,a0,a1 lit
    check("rev_lap_drop", int'(lap), 0);

    // Clockwise to head 3, then hold for 20 cycles.
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (head_pos == 3) found = 1;
    end
    check("reach_h3", found, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    check("hold_head", int'(head_pos), 3);
    check("hold_seg", int'(seg_n), 'h07FF);  // a1,b1,c1 lit
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    // Reset mid-run aborts immediately; en high leaves blank right after.
    step(1'b1, 1'b1, 1'b0);
    check("rst_seg", int'(seg_n), 'h3FFF);
    check("rst_head", int'(head_pos), 0);
    check("rst_lap", int'(lap), 0);
    step(1'b0, 1'b1, 1'b0);
    check("rst_exit_seg", int'(seg_n), 'h3FFF);
    step(1'b0, 1'b1, 1'b0);
    check("rst_run_seg", int'(seg_n), 'h3FB9);

    // Randomized run/hold/direction/reset against the model.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), dir ^ ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
